mem_bus_unit: RTL and testbench
===============================

# mem_bus_unit

Memory-access stage between the multicycle control FSM and the external memory bus. It turns the FSM's MemRead/MemWrite/IorD strobes into a valid/ready bus transaction. It stalls the FSM with `busy` until the transaction completes, and it owns the instruction register and memory data register. It also performs RV32 byte/halfword/word store lane steering and load alignment with sign/zero extension.

## Interface
- `ADDR_W`, default 32: byte-address width of `pc`, `alu_out` and `bus_addr`.
- `clk` in 1: single clock; all state changes on its rising edge.
- `reset` in 1: asynchronous, active-high; clears all state immediately.
- `mem_read` in 1: read request level from control FSM.
- `mem_write` in 1: write request level from control FSM.
- `iord` in 1: address select. 0 = `pc` (instruction fetch, always word). 1 = `alu_out` (data access).
- `pc` in ADDR_W: fetch address.
- `alu_out` in ADDR_W: data address.
- `funct3` in 3: access size/sign for data accesses; ignored when `iord`=0.
- `store_data` in 32: rs2 value to store.
- `busy` out 1: stall to control FSM.
- `instr` out 32: instruction register.
- `mdr` out 32: extended load data.
- `misaligned` out 1: one-cycle error pulse.
- `bus_valid` out 1: request valid.
- `bus_we` out 1: 1 = write.
- `bus_addr` out ADDR_W: word-aligned address (bits [1:0] = 00).
- `bus_wdata` out 32: lane-replicated store data.
- `bus_wstrb` out 4: byte enables; 0000 on reads.
- `bus_ready` in 1: slave accepts/completes the request this cycle.
- `bus_rdata` in 32: read data, valid when `bus_valid & bus_ready & !bus_we`.

## Operation
- FSM states: IDLE, REQ, DONE.
- **IDLE**, no request: stay in IDLE.
- **IDLE**, request (`mem_read|mem_write`): accept the request.
  - Latch the address (`iord ? alu_out : pc`), `we`, `funct3`, byte offset `addr[1:0]`, `wdata`, `wstrb`, and the destination (instr if `iord`=0, else mdr).
  - Go to REQ, or to DONE if the access is misaligned/illegal.
- **Simultaneous `mem_read` and `mem_write`**: write wins; the read is dropped.
- **REQ**: drive `bus_valid`=1 with all bus outputs held stable from the latched values.
  - Stay in REQ while `bus_ready`=0.
  - On `bus_ready`=1, capture a read into its destination and go to DONE.
  - Writes capture nothing.
- **DONE**: one cycle; requests are ignored; go to IDLE.
- **Misaligned/illegal access** (no bus transaction; `instr` and `mdr` unchanged; `misaligned`=1 during the DONE cycle):
  - fetch with `pc[1:0]`≠0;
  - halfword with `addr[0]`=1;
  - word with `addr[1:0]`≠0;
  - `funct3` ∈ {011, 110, 111}.
- **Store steering**, off = `addr[1:0]`:
  - SB (x00): `wdata` = {4{sd[7:0]}}, `wstrb` = 0001<<off.
  - SH (x01): `wdata` = {2{sd[15:0]}}, `wstrb` = 0011<<off.
  - SW (010): `wdata` = sd, `wstrb` = 1111.
- **Load alignment**: shift `bus_rdata` right by 8·off.
  - LB/LH sign-extend bit 7/15.
  - LBU/LHU (funct3[2]=1) zero-extend.
  - LW passes 32 bits.
- **Fetch**: `instr` ← `bus_rdata` unmodified.
- **`busy`** = (IDLE & (`mem_read|mem_write`)) | REQ. This is combinational, so the FSM stalls in the same cycle it raises a request. `busy` is 0 in DONE, which lets the FSM advance exactly once per access.
- **Reset values**:
  - state = IDLE;
  - `instr` = `mdr` = 0x00000000;
  - `bus_valid` = `bus_we` = `misaligned` = 0, `bus_wstrb` = 0000, `bus_addr` = `bus_wdata` = 0;
  - `busy` = 0 unless a request is present.
- **Reset mid-transaction**: `bus_valid` drops asynchronously, nothing is captured, and the access is lost (the FSM is reset alongside).

## Timing
- Zero-wait slave:
  - Cycle T0: IDLE + request, `busy`=1.
  - Cycle T1: REQ with `bus_ready`=1, `busy`=1; capture at the T1 edge.
  - Cycle T2: DONE, `busy`=0, `instr`/`mdr` valid.
- Each wait state (`bus_ready`=0 in REQ) adds one `busy` cycle.
- Minimum spacing between accepted requests is 3 cycles (IDLE, REQ, DONE).
- Misaligned access:
  - Cycle T0: `busy`=1.
  - Cycle T1: DONE with `misaligned`=1 and `busy`=0.
- Bus outputs change only on the transition into REQ and are constant throughout REQ (AXI-lite-style valid stability).
- `instr`/`mdr` update only on the clock edge that completes a read. Otherwise they hold.

## Test plan
- Fetch, `pc`=0x100, `bus_rdata`=0x00A00093, ready in the first REQ cycle -> `bus_addr`=0x100, `busy` high 2 cycles, `instr`=0x00A00093 in DONE, `mdr` unchanged.
- LB from `alu_out`=0x203, `funct3`=000, `bus_rdata`=0x80FF1234 -> `mdr`=0xFFFFFF80. Repeat with LBU (100) -> `mdr`=0x00000080. LH at 0x202 -> `mdr`=0xFFFF80FF.
- SH at 0x106, `store_data`=0xDEADBEEF -> `bus_we`=1, `bus_addr`=0x104, `bus_wstrb`=1100, `bus_wdata`=0xBEEFBEEF. SB at 0x101 -> `wstrb`=0010.
- Read with 3 wait states, `alu_out` toggled during REQ -> `bus_addr` stays latched, `busy` high 5 cycles, a single capture.
- LW at 0x102, and fetch at `pc`=0x002 -> no `bus_valid`, `misaligned`=1 for one cycle, `busy` high 1 cycle, `mdr`/`instr` unchanged.
- Assert `reset` during REQ with `bus_ready`=0 -> `bus_valid`=0 immediately, state IDLE. The next fetch completes normally. `mem_read`+`mem_write` together -> write transaction only.

Source files
------------

// File: rtl/mem_bus_unit.sv
// Memory-access stage: turns control-FSM strobes into a valid/ready bus
// transaction, owns IR/MDR, and steers store lanes / aligns load data.
module mem_bus_unit #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              iord,
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] alu_out,
  input  logic [2:0]        funct3,
  input  logic [31:0]       store_data,
  output logic              busy,
  output logic [31:0]       instr,
  output logic [31:0]       mdr,
  output logic              misaligned,
  output logic              bus_valid,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [31:0]       bus_wdata,
  output logic [3:0]        bus_wstrb,
  input  logic              bus_ready,
  input  logic [31:0]       bus_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DONE
  } state_t;

  state_t state, state_n;

  logic [2:0] f3_q;
  logic [1:0] off_q;
  logic       dst_q;
  logic       mis_q;

  logic              req;
  logic [ADDR_W-1:0] addr;
  logic [1:0]        off;
  logic [1:0]        size;
  logic              illegal;
  logic              mis;
  logic [31:0]       wdata_c;
  logic [3:0]        wstrb_c;
  logic [31:0]       sh;
  logic [31:0]       ld;

  assign req  = mem_read | mem_write;
  assign addr = iord ? alu_out : pc;
  assign off  = addr[1:0];

  // size: 0 = byte, 1 = half, 2 = word; fetches are always word
  always_comb begin
    size = 2'd2;
    if (iord) begin
      unique case (funct3[1:0])
        2'b00:   size = 2'd0;
        2'b01:   size = 2'd1;
        default: size = 2'd2;
      endcase
    end
  end

  assign illegal = iord &
    ((funct3 == 3'b011) | (funct3[2:1] == 2'b11));
  assign mis = illegal |
    ((size == 2'd1) & off[0]) |
    ((size == 2'd2) & (off != 2'b00));

  always_comb begin
    wdata_c = store_data;
    wstrb_c = 4'b1111;
    unique case (size)
      2'd0: begin
        wdata_c = {4{store_data[7:0]}};
        wstrb_c = 4'b0001 << off;
      end
      2'd1: begin
        wdata_c = {2{store_data[15:0]}};
        wstrb_c = 4'b0011 << off;
      end
      default: begin
        wdata_c = store_data;
        wstrb_c = 4'b1111;
      end
    endcase
    if (!mem_write) wstrb_c = 4'b0000;
  end

  assign sh = bus_rdata >> {off_q, 3'b000};

  always_comb begin
    ld = sh;
    unique case (f3_q[1:0])
      2'b00:   ld = {{24{~f3_q[2] & sh[7]}}, sh[7:0]};
      2'b01:   ld = {{16{~f3_q[2] & sh[15]}}, sh[15:0]};
      default: ld = sh;
    endcase
  end

  always_comb begin
    state_n = state;
    busy    = 1'b0;
    unique case (state)
      IDLE: begin
        if (req) begin
          busy    = 1'b1;
          state_n = mis ? DONE : REQ;
        end
      end
      REQ: begin
        busy = 1'b1;
        if (bus_ready) state_n = DONE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus_valid  = (state == REQ);
  assign misaligned = (state == DONE) & mis_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      f3_q      <= 3'b000;
      off_q     <= 2'b00;
      dst_q     <= 1'b0;
      mis_q     <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= 32'h0;
      bus_wstrb <= 4'b0000;
      instr     <= 32'h0;
      mdr       <= 32'h0;
    end else begin
      state <= state_n;
      if (state == IDLE && req) begin
        f3_q  <= funct3;
        off_q <= off;
        dst_q <= iord;
        mis_q <= mis;
        // bus outputs move only when a real transaction starts
        if (!mis) begin
          bus_addr  <= {addr[ADDR_W-1:2], 2'b00};
          bus_we    <= mem_write;
          bus_wdata <= wdata_c;
          bus_wstrb <= wstrb_c;
        end
      end
      if (state == REQ && bus_ready && !bus_we) begin
        if (dst_q) mdr   <= ld;
        else       instr <= bus_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_bus_unit.sv
// Self-checking bench for mem_bus_unit: directed plan cases plus
// randomized accesses against a byte-level reference model.
module tb_mem_bus_unit;

  logic        clk;
  logic        reset;
  logic        mem_read;
  logic        mem_write;
  logic        iord;
  logic [31:0] pc;
  logic [31:0] alu_out;
  logic [2:0]  funct3;
  logic [31:0] store_data;
  logic        busy;
  logic [31:0] instr;
  logic [31:0] mdr;
  logic        misaligned;
  logic        bus_valid;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_ready;
  logic [31:0] bus_rdata;

  int checks;
  int errors;

  logic [31:0] m_instr;
  logic [31:0] m_mdr;

  mem_bus_unit #(.ADDR_W(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .iord       (iord),
    .pc         (pc),
    .alu_out    (alu_out),
    .funct3     (funct3),
    .store_data (store_data),
    .busy       (busy),
    .instr      (instr),
    .mdr        (mdr),
    .misaligned (misaligned),
    .bus_valid  (bus_valid),
    .bus_we     (bus_we),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_wstrb  (bus_wstrb),
    .bus_ready  (bus_ready),
    .bus_rdata  (bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: one complete access, expectations from byte arithmetic
  task automatic access(input bit rd, input bit wr, input bit io,
                        input logic [31:0] a_pc,
                        input logic [31:0] a_alu,
                        input logic [2:0] f3,
                        input logic [31:0] sd,
                        input logic [31:0] rdata,
                        input int waits);
    logic [31:0] a;
    int          nb;
    int          off;
    bit          mis;
    bit          we;
    logic [31:0] e_addr;
    logic [3:0]  e_strb;
    logic [31:0] e_wdata;
    longint      v;
    a   = io ? a_alu : a_pc;
    off = int'(a % 4);
    we  = wr;
    nb  = 4;
    if (io && f3[1:0] == 2'b00) nb = 1;
    if (io && f3[1:0] == 2'b01) nb = 2;
    mis = (off % nb) != 0;
    if (io && (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)) mis = 1;
    e_addr = a - 32'(off);
    e_strb = we ? 4'(((1 << nb) - 1) << off) : 4'b0000;
    if (nb == 1)      e_wdata = 32'(sd[7:0]) * 32'h01010101;
    else if (nb == 2) e_wdata = 32'(sd[15:0]) * 32'h00010001;
    else              e_wdata = sd;
    if (!mis && !we) begin
      v = longint'(rdata) / (longint'(1) << (8 * off));
      v = v % (longint'(1) << (8 * nb));
      if (io && !f3[2] && nb < 4 && v >= (longint'(1) << (8 * nb - 1)))
        v = v - (longint'(1) << (8 * nb));
      if (io) m_mdr = 32'(v);
      else    m_instr = rdata;
    end

    @(posedge clk); #1;
    mem_read = rd; mem_write = wr; iord = io;
    pc = a_pc; alu_out = a_alu; funct3 = f3; store_data = sd;
    bus_ready = 1'b0; bus_rdata = $urandom;
    @(negedge clk);
    check("t0_busy", 32'(busy), 32'd1);
    check("t0_valid", 32'(bus_valid), 32'd0);
    @(posedge clk); #1;
    if (!mis) begin
      for (int k = 0; k <= waits; k++) begin
        bus_ready = (k == waits);
        bus_rdata = (k == waits) ? rdata : $urandom;
        alu_out   = $urandom;
        pc        = $urandom;
        @(negedge clk);
        check("req_valid", 32'(bus_valid), 32'd1);
        check("req_busy", 32'(busy), 32'd1);
        check("req_addr", bus_addr, e_addr);
        check("req_we", 32'(bus_we), 32'(we));
        check("req_strb", 32'(bus_wstrb), 32'(e_strb));
        if (we) check("req_wdata", bus_wdata, e_wdata);
        @(posedge clk); #1;
      end
      bus_ready = 1'b0;
      bus_rdata = $urandom;
    end
    @(negedge clk);
    check("done_busy", 32'(busy), 32'd0);
    check("done_valid", 32'(bus_valid), 32'd0);
    check("done_mis", 32'(misaligned), 32'(mis));
    check("done_instr", instr, m_instr);
    check("done_mdr", mdr, m_mdr);
    @(posedge clk); #1;
    mem_read = 1'b0; mem_write = 1'b0;
    @(negedge clk);
    check("idle_mis", 32'(misaligned), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_instr", instr, m_instr);
    check("idle_mdr", mdr, m_mdr);
  endtask

  initial begin
    checks = 0; errors = 0;
    m_instr = 32'h0; m_mdr = 32'h0;
    reset = 1'b1; mem_read = 1'b0; mem_write = 1'b0; iord = 1'b0;
    pc = 32'h0; alu_out = 32'h0; funct3 = 3'b000;
    store_data = 32'h0; bus_ready = 1'b0; bus_rdata = 32'h0;
    repeat (2) @(negedge clk);
    check("rst_instr", instr, 32'h0);
    check("rst_mdr", mdr, 32'h0);
    check("rst_valid", 32'(bus_valid), 32'd0);
    check("rst_we", 32'(bus_we), 32'd0);
    check("rst_strb", 32'(bus_wstrb), 32'd0);
    check("rst_addr", bus_addr, 32'h0);
    check("rst_wdata", bus_wdata, 32'h0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_mis", 32'(misaligned), 32'd0);
    reset = 1'b0;

    access(1, 0, 0, 32'h100, 32'h0, 3'b000, 32'h0, 32'h00A00093, 0);
    check("plan_instr", instr, 32'h00A00093);
    access(1, 0, 1, 32'h0, 32'h203, 3'b000, 32'h0, 32'h80FF1234, 0);
    check("plan_lb", mdr, 32'hFFFFFF80);
    access(1, 0, 1, 32'h0, 32'h203, 3'b100, 32'h0, 32'h80FF1234, 0);
    check("plan_lbu", mdr, 32'h00000080);
    access(1, 0, 1, 32'h0, 32'h202, 3'b001, 32'h0, 32'h80FF1234, 0);
    check("plan_lh", mdr, 32'hFFFF80FF);
    access(0, 1, 1, 32'h0, 32'h106, 3'b001, 32'hDEADBEEF, 32'h0, 0);
    access(0, 1, 1, 32'h0, 32'h101, 3'b000, 32'hDEADBEEF, 32'h0, 1);
    access(1, 0, 1, 32'h0, 32'h300, 3'b010, 32'h0, 32'h12345678, 3);
    check("plan_lw_wait", mdr, 32'h12345678);
    access(1, 0, 1, 32'h0, 32'h102, 3'b010, 32'h0, 32'h0, 0);
    access(1, 0, 0, 32'h002, 32'h0, 3'b000, 32'h0, 32'h0, 0);
    access(1, 1, 1, 32'h0, 32'h400, 3'b010, 32'hCAFEF00D, 32'h0, 0);

    // reset while waiting in REQ
    @(posedge clk); #1;
    mem_read = 1'b1; iord = 1'b0; pc = 32'h200;
    bus_ready = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("pre_rst_valid", 32'(bus_valid), 32'd1);
    #1 reset = 1'b1; mem_read = 1'b0;
    #1;
    check("async_valid", 32'(bus_valid), 32'd0);
    check("async_busy", 32'(busy), 32'd0);
    check("async_instr", instr, 32'h0);
    m_instr = 32'h0; m_mdr = 32'h0;
    @(negedge clk);
    reset = 1'b0;
    access(1, 0, 0, 32'h204, 32'h0, 3'b000, 32'h0, 32'h00B00113, 0);
    check("post_rst_instr", instr, 32'h00B00113);

    for (int i = 0; i < 60; i++) begin
      int          op;
      bit          io;
      logic [31:0] a;
      op = $urandom_range(0, 2);
      io = (op != 0) ? 1'b1 : 1'($urandom_range(0, 1));
      a  = $urandom;
      if ($urandom_range(0, 2) == 0) a[1:0] = 2'b00;
      access(op != 1, op != 0, io, a, a ^ 32'h5A5A_0000,
             3'($urandom_range(0, 7)), $urandom, $urandom,
             $urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
